// File: rtl/cond_exec_ctrl.sv
// Condition-execution controller between ID and EXE: owns NZCV, tracks in-flight
// flag writers, stalls conditionals until flags resolve and issues or squashes them.
module cond_exec_ctrl #(
   parameter int unsigned MAX_PEND = 3,
   parameter int unsigned CNT_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_cond,
   input  logic             id_set_flags,
   output logic             id_ready,
   input  logic             flush,
   input  logic             wb_flag_valid,
   input  logic [3:0]       wb_flags,
   output logic             ex_issue,
   output logic             ex_squash,
   output logic [3:0]       status_out,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             wb_err
);

   typedef enum logic [1:0] {StRun, StWaitFlags, StFull} stateE;

   stateE            stateQ, stateD;
   logic [3:0]       statusQ;
   logic [CNT_W-1:0] pendQ;
   logic             exIssueQ, exSquashQ, wbErrQ;

   logic       pendZero, pendOne, pendFull, resolved;
   logic       waitCond, fullStall, accept, pass, inc, dec;
   logic [3:0] flags;

   function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, res;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      unique case (cond)
         4'h0:    res = z;
         4'h1:    res = !z;
         4'h2:    res = c;
         4'h3:    res = !c;
         4'h4:    res = n;
         4'h5:    res = !n;
         4'h6:    res = v;
         4'h7:    res = !v;
         4'h8:    res = c & !z;
         4'h9:    res = !c | z;
         4'hA:    res = (n == v);
         4'hB:    res = (n != v);
         4'hC:    res = !z & (n == v);
         4'hD:    res = z | (n != v);
         4'hE:    res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   always_comb begin
      pendZero  = (pendQ == '0);
      pendOne   = (pendQ == CNT_W'(1));
      pendFull  = (pendQ == CNT_W'(MAX_PEND));
      resolved  = pendZero | (pendOne & wb_flag_valid);
      // The last outstanding writer retiring this cycle forwards its flags directly.
      flags     = (wb_flag_valid & pendOne) ? wb_flags : statusQ;
      waitCond  = (id_cond != 4'hE) & !resolved;
      fullStall = id_set_flags & pendFull & !wb_flag_valid;
      id_ready  = rst & (!id_valid | !(waitCond | fullStall));
      accept    = id_valid & id_ready & !flush;
      pass      = condPass(id_cond, flags);
      // A squashed flag-setter never writes back, so it is not counted.
      inc       = accept & id_set_flags & pass;
      dec       = wb_flag_valid & !pendZero;
      stateD    = StRun;
      if (id_valid && !flush) begin
         if (waitCond)       stateD = StWaitFlags;
         else if (fullStall) stateD = StFull;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StRun;
         statusQ   <= 4'b0000;
         pendQ     <= '0;
         exIssueQ  <= 1'b0;
         exSquashQ <= 1'b0;
         wbErrQ    <= 1'b0;
      end else begin
         stateQ    <= stateD;
         exIssueQ  <= accept & pass;
         exSquashQ <= accept & !pass;
         if (inc && !dec)      pendQ <= pendQ + CNT_W'(1);
         else if (dec && !inc) pendQ <= pendQ - CNT_W'(1);
         if (wb_flag_valid) statusQ <= wb_flags;
         if (wb_flag_valid && pendZero && !inc) wbErrQ <= 1'b1;
      end
   end

   // A held instruction implies the counter condition that caused the hold still stands.
   assert property (@(posedge clk) disable iff (!rst) (stateQ == StFull) |-> pendFull);
   assert property (@(posedge clk) disable iff (!rst) (stateQ == StWaitFlags) |-> !pendZero);

   assign ex_issue   = exIssueQ;
   assign ex_squash  = exSquashQ;
   assign status_out = statusQ;
   assign pend_cnt   = pendQ;
   assign wb_err     = wbErrQ;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Table-driven bench for cond_exec_ctrl with an issue/squash scoreboard queue.
module tb_cond_exec_ctrl;

   logic       clk, rst;
   logic       id_valid, id_set_flags, id_ready, flush;
   logic [3:0] id_cond;
   logic       wb_flag_valid;
   logic [3:0] wb_flags;
   logic       ex_issue, ex_squash, wb_err;
   logic [3:0] status_out;
   logic [1:0] pend_cnt;

   cond_exec_ctrl #(.MAX_PEND(3), .CNT_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_cond      (id_cond),
      .id_set_flags (id_set_flags),
      .id_ready     (id_ready),
      .flush        (flush),
      .wb_flag_valid(wb_flag_valid),
      .wb_flags     (wb_flags),
      .ex_issue     (ex_issue),
      .ex_squash    (ex_squash),
      .status_out   (status_out),
      .pend_cnt     (pend_cnt),
      .wb_err       (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [3:0] cond;
      logic       sf, fl, wbv;
      logic [3:0] wbf;
      logic       rdy, iss, sq;
      logic [1:0] pend;
      logic [3:0] st;
      logic       err;
   } vecT;

   vecT        vecs[$];
   logic [1:0] sb[$];
   int         nTests = 0;
   int         nFail  = 0;
   int         curRow = 0;

   function automatic vecT mk(input logic v, input logic [3:0] cond, input logic sf,
                              input logic fl, input logic wbv, input logic [3:0] wbf,
                              input logic rdy, input logic iss, input logic sq,
                              input logic [1:0] pend, input logic [3:0] st, input logic err);
      vecT r;
      r.v = v; r.cond = cond; r.sf = sf; r.fl = fl; r.wbv = wbv; r.wbf = wbf;
      r.rdy = rdy; r.iss = iss; r.sq = sq; r.pend = pend; r.st = st; r.err = err;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s (row %0d): got %0h, expected %0h", nm, curRow, act, exp);
      end
   endtask

   task automatic applyRow(input vecT r);
      logic [1:0] e;
      @(negedge clk);
      id_valid = r.v; id_cond = r.cond; id_set_flags = r.sf; flush = r.fl;
      wb_flag_valid = r.wbv; wb_flags = r.wbf;
      #1;
      chk("id_ready", id_ready, r.rdy);
      sb.push_back({r.iss, r.sq});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("ex_issue", ex_issue, e[1]);
         chk("ex_squash", ex_squash, e[0]);
      end
      chk("pend_cnt", pend_cnt, r.pend);
      chk("status_out", status_out, r.st);
      chk("wb_err", wb_err, r.err);
   endtask

   initial begin
      rst = 1'b0;
      id_valid = 0; id_cond = 0; id_set_flags = 0; flush = 0; wb_flag_valid = 0; wb_flags = 0;

      //             v cond sf fl wbv wbf  rdy iss sq pend st  err
      vecs.push_back(mk(1, 4'hE, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'h0, 0)); // AL
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 1, 4'h0, 0)); // ADDS
      vecs.push_back(mk(1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0)); // BEQ stalls
      vecs.push_back(mk(1, 4'h0, 0, 0, 1, 4'h4, 1, 1, 0, 0, 4'h4, 0)); // BEQ via forward
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 1, 4'h4, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h9, 1, 0, 0, 0, 4'h9, 0)); // NZCV=1001
      vecs.push_back(mk(1, 4'hA, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'h9, 0)); // GE
      vecs.push_back(mk(1, 4'hB, 0, 0, 0, 4'h0, 1, 0, 1, 0, 4'h9, 0)); // LT
      vecs.push_back(mk(1, 4'hC, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'h9, 0)); // GT
      vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 1, 0, 4'h9, 0)); // NV
      vecs.push_back(mk(1, 4'h4, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'h9, 0)); // MI
      vecs.push_back(mk(1, 4'h8, 0, 0, 0, 4'h0, 1, 0, 1, 0, 4'h9, 0)); // HI
      vecs.push_back(mk(1, 4'hF, 1, 0, 0, 4'h0, 1, 0, 1, 0, 4'h9, 0)); // squashed setter
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 1, 4'h9, 0));
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 2, 4'h9, 0));
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 3, 4'h9, 0));
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 0, 0, 0, 3, 4'h9, 0)); // FULL
      vecs.push_back(mk(1, 4'hE, 1, 0, 1, 4'h2, 1, 1, 0, 3, 4'h2, 0)); // +1/-1 same cycle
      vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h0, 1, 0, 0, 2, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h0, 1, 0, 0, 1, 4'h0, 0));
      vecs.push_back(mk(1, 4'h1, 0, 0, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0)); // NE held
      vecs.push_back(mk(1, 4'h1, 0, 1, 0, 4'h0, 0, 0, 0, 1, 4'h0, 0)); // flushed
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 1, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h6, 1, 0, 0, 0, 4'h6, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'hF, 1, 0, 0, 0, 4'hF, 1)); // stray writeback
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 4'hF, 1)); // sticky
      vecs.push_back(mk(1, 4'hE, 1, 1, 0, 4'h0, 1, 0, 0, 0, 4'hF, 1)); // flush blocks accept
      vecs.push_back(mk(1, 4'h0, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'hF, 1)); // EQ, Z=1
      vecs.push_back(mk(1, 4'hE, 1, 0, 0, 4'h0, 1, 1, 0, 1, 4'hF, 1));

      repeat (3) @(posedge clk);
      #1;
      curRow = -1;
      chk("rst_id_ready", id_ready, 0);
      chk("rst_ex_issue", ex_issue, 0);
      chk("rst_ex_squash", ex_squash, 0);
      chk("rst_status", status_out, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_wb_err", wb_err, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         curRow = i;
         applyRow(vecs[i]);
      end

      // Reset asserted asynchronously while a BEQ is stalled behind an in-flight writer.
      curRow = 100;
      @(negedge clk);
      id_valid = 1; id_cond = 4'h0; id_set_flags = 0; flush = 0; wb_flag_valid = 0;
      #1;
      chk("stall_ready", id_ready, 0);
      @(posedge clk);
      #1;
      chk("stall_issue", ex_issue, 0);
      chk("stall_squash", ex_squash, 0);
      #1;
      rst = 1'b0;
      id_valid = 0;
      #1;
      chk("arst_ready", id_ready, 0);
      chk("arst_status", status_out, 0);
      chk("arst_pend", pend_cnt, 0);
      chk("arst_wb_err", wb_err, 0);
      chk("arst_issue", ex_issue, 0);
      chk("arst_squash", ex_squash, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_ready", id_ready, 1);
      @(posedge clk);
      #1;
      chk("post_rst_issue", ex_issue, 0);
      chk("post_rst_squash", ex_squash, 0);
      chk("post_rst_pend", pend_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- Condition-execution controller between ID and EXE stages of the ARM pipeline.
- Owns the NZCV status register and tracks flag-setting instructions still in flight.
- Stalls conditional instructions until their flags are resolved, evaluates the 4-bit condition field, and emits a registered issue or squash decision per accepted instruction.

Parameters:
MAX_PEND, 3, maximum number of issued flag-setting instructions awaiting flag writeback.
CNT_W, 2, width of the pending counter; must hold MAX_PEND.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
id_valid  input  1  ID stage presents an instruction.
id_cond  input  4  condition field of the ID instruction.
id_set_flags  input  1  ID instruction updates NZCV (S bit).
id_ready  output  1  controller accepts the ID instruction this cycle.
flush  input  1  discard the current ID instruction.
wb_flag_valid  input  1  flag writeback strobe from the flag-writing stage.
wb_flags  input  4  writeback NZCV value: [3]N [2]Z [1]C [0]V.
ex_issue  output  1  registered pulse: last accepted instruction executes.
ex_squash  output  1  registered pulse: last accepted instruction becomes a NOP.
status_out  output  4  current NZCV register.
pend_cnt  output  CNT_W  number of flag writers in flight.
wb_err  output  1  sticky flag: writeback arrived with pend_cnt==0.

Behaviour:
- Reset (rst=0, async): status_out=0, pend_cnt=0, ex_issue=0, ex_squash=0, wb_err=0, state=RUN. id_ready=0 while reset is asserted.
- Condition decode, using flags F (N,Z,C,V):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL always passes; F never passes.
- Flag source F:
  - F = wb_flags when wb_flag_valid=1 and pend_cnt==1 (same-cycle forward).
  - Otherwise F = status_out.
- Flags resolved: pend_cnt==0, or (pend_cnt==1 and wb_flag_valid=1).
- FSM states:
  - RUN: idle or accepting.
  - WAIT_FLAGS: a conditional instruction is held.
  - FULL: a flag-setter is held because pend_cnt==MAX_PEND.
- id_ready (combinational):
  - 0 if id_cond!=E and flags are not resolved; enter or stay in WAIT_FLAGS.
  - Else 0 if id_set_flags=1 and pend_cnt==MAX_PEND and wb_flag_valid=0; enter or stay in FULL.
  - Else 1; return to RUN.
  - With id_valid=0, id_ready=1 and state=RUN.
- Accept occurs when id_valid & id_ready & !flush.
  - The cycle after accept: ex_issue=pass or ex_squash=!pass, exactly one high.
  - Both outputs are 0 in every other cycle. Latency is 1 cycle.
- flush=1: no accept, no issue or squash pulse, state returns to RUN next cycle. In-flight writers and pend_cnt are unaffected.
- pend_cnt:
  - +1 on accept of an instruction with id_set_flags=1 and pass=1. A squashed flag-setter never writes flags and is not counted.
  - -1 on wb_flag_valid when pend_cnt>0.
  - Simultaneous +1 and -1: unchanged.
  - Never exceeds MAX_PEND. Wraps never.
- Status register: loads wb_flags on every wb_flag_valid, including when pend_cnt==0.
- wb_err: set to 1 on wb_flag_valid with pend_cnt==0 and no same-cycle increment. Cleared only by reset.
- Reset mid-stall: all state is cleared, pend_cnt=0, and the held instruction is neither issued nor squashed.

Test Plan:
- Reset, then id_valid=1, cond=E, set_flags=0 -> id_ready=1; next cycle ex_issue=1, ex_squash=0; status_out=0000.
- Accept an ADDS (cond=E, set_flags=1), then BEQ (cond=0) next cycle -> id_ready=0, state WAIT_FLAGS, pend_cnt=1. Then wb_flag_valid=1 with wb_flags=0100 -> BEQ accepted that cycle via forward; next cycle ex_issue=1, status_out=0100, pend_cnt=0.
- status_out=1001 (N=1, V=1): cond A (GE) -> ex_issue; cond B (LT) -> ex_squash; cond C (GT) -> ex_issue; cond F -> ex_squash, each with 1-cycle latency.
- Issue 3 flag-setters back-to-back with no writeback -> pend_cnt=3; the 4th flag-setter sees id_ready=0 (FULL). wb_flag_valid in the same cycle -> 4th accepted, pend_cnt stays 3.
- Hold cond=1 (NE) in WAIT_FLAGS and assert flush=1 -> no ex_issue or ex_squash; pend_cnt unchanged; state RUN next cycle.
- wb_flag_valid=1 with pend_cnt=0 -> wb_err=1 and stays 1; status_out=wb_flags. Assert rst=0 asynchronously mid-stall -> all outputs 0 immediately.
